chrono_ctrl: RTL and testbench
==============================

CHRONO_CTRL -- requirements
Module: chrono_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 100000: CLK cycles per count TICK; legal range >= 2.
REQ-002 SHALL have parameter DEB_CYCLES, default 20000: cycles a synchronized button level must be stable before it is accepted; legal range >= 1.
REQ-003 SHALL have port CLK  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port BTN_SS  input  1  raw start/stop button; asynchronous to CLK, active-high, bouncing.
REQ-006 SHALL have port BTN_CLR  input  1  raw clear button; asynchronous to CLK, active-high, bouncing.
REQ-007 SHALL have port TICK  output  1  one-cycle count-enable pulse for the downstream BCD digit counter.
REQ-008 SHALL have port CLR  output  1  one-cycle synchronous clear request for the downstream counter.
REQ-009 SHALL have port STATE  output  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE; 11 never driven.
REQ-010 SHALL have port RUNNING  output  1  high exactly when STATE == RUN.

Function
REQ-011 Each of BTN_SS and BTN_CLR SHALL pass through its own two-flop synchronizer before any other use.
REQ-012 Each button SHALL have a debouncer that updates its debounced level only after the synchronized level differs from it for DEB_CYCLES consecutive cycles; any mismatch break restarts the count from 0.
REQ-013 A press pulse SHALL be asserted for exactly one cycle on each 0->1 transition of a debounced level; 1->0 transitions produce nothing.
REQ-014 Holding a button SHALL produce exactly one press pulse, with no auto-repeat.
REQ-015 FSM transitions SHALL take effect on the clock edge after the press pulse cycle.
REQ-016 IDLE + ss press SHALL go to RUN.
REQ-017 RUN + ss press SHALL go to PAUSE.
REQ-018 PAUSE + ss press SHALL go to RUN.
REQ-019 PAUSE + clr press SHALL go to IDLE.
REQ-020 IDLE + clr press SHALL stay in IDLE.
REQ-021 RUN + clr press SHALL be ignored.
REQ-022 CLR SHALL be a registered output that pulses for one cycle, in the cycle after any honored clr press (IDLE or PAUSE).
REQ-023 Simultaneous ss and clr press pulses SHALL be resolved as follows: in IDLE or PAUSE, clear wins, ss is dropped, state goes to or stays in IDLE, and CLR pulses; in RUN, ss is honored and clr is dropped.
REQ-024 Prescaler SHALL be a counter of width $clog2(DIV) ranging 0..DIV-1.
REQ-025 The prescaler SHALL increment only in RUN and wrap DIV-1 -> 0.
REQ-026 The prescaler SHALL hold its value in PAUSE so that phase is preserved on resume.
REQ-027 The prescaler SHALL be forced to 0 in IDLE.
REQ-028 TICK SHALL be asserted combinationally while STATE == RUN and prescaler == DIV-1, giving exactly one TICK every DIV cycles in RUN.
REQ-029 The first TICK after IDLE->RUN SHALL occur in the DIV-th cycle in RUN, counting the first RUN cycle as cycle 1.
REQ-030 TICK SHALL never be asserted in IDLE or PAUSE, including in the cycle when RUN->PAUSE takes effect.
REQ-031 TICK and CLR SHALL never be high in the same cycle.

Reset
REQ-032 On RST low, the block SHALL asynchronously set STATE=IDLE, RUNNING=0, TICK=0 and CLR=0, and clear the prescaler, both debounce counters, both debounced levels and both synchronizer flops to 0.
REQ-033 After RST rises, a button already held high SHALL be treated as a new press once debounced.
REQ-034 Reset asserted mid-RUN or mid-debounce SHALL abort the operation with no TICK or CLR pulse emitted.

Verification (DIV=10, DEB_CYCLES=4)
REQ-035 Bench SHALL cover: clean BTN_SS held 20 cycles from IDLE -> exactly one ss press; STATE=01 six cycles after first synchronized sample; TICK every 10 cycles, first in the 10th RUN cycle.
REQ-036 Bench SHALL cover: BTN_SS toggling every 2 cycles for 30 cycles, then low -> no press pulse, STATE stays 00, TICK never asserted.
REQ-037 Bench SHALL cover: RUN, pause at prescaler=6, wait 50 cycles, resume -> no TICK during PAUSE; first TICK in the 4th RUN cycle after resume.
REQ-038 Bench SHALL cover: BTN_CLR press in RUN -> ignored, no CLR; pause, then BTN_CLR -> single CLR pulse, STATE=00, prescaler=0.
REQ-039 Bench SHALL cover: BTN_SS and BTN_CLR pressed the same cycle in PAUSE -> STATE=00, one CLR pulse; same stimulus in RUN -> STATE=10, no CLR.
REQ-040 Bench SHALL cover: RST pulsed low mid-RUN at prescaler=5 -> immediate STATE=00, TICK=0, CLR=0; after release, no TICK without a new ss press.

Source files
------------

// File: rtl/chrono_ctrl.sv
// rtl/chrono_ctrl.sv - stopwatch control: button conditioning, run/pause/idle FSM, tick prescaler
module chrono_ctrl #(
    parameter int DIV        = 100000,
    parameter int DEB_CYCLES = 20000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_SS,
    input  logic       BTN_CLR,
    output logic       TICK,
    output logic       CLR,
    output logic [1:0] STATE,
    output logic       RUNNING
);

    localparam int PW = $clog2(DIV);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10
    } state_t;

    // index 0 = start/stop, index 1 = clear
    logic [1:0]         btn_raw;
    logic [1:0]         sync_1;
    logic [1:0]         sync_2;
    logic [1:0]         deb_lvl;
    logic [1:0]         deb_prev;
    logic [1:0][DW-1:0] deb_cnt;
    logic [1:0]         press;
    logic               ss_press;
    logic               clr_press;

    state_t             state;
    state_t             state_nxt;
    logic               clr_hon;
    logic [PW-1:0]      presc;

    assign btn_raw   = {BTN_CLR, BTN_SS};
    assign press     = deb_lvl & ~deb_prev;
    assign ss_press  = press[0];
    assign clr_press = press[1];

    // two-flop synchronizers for both raw buttons
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
        end
    end

    // debounce: accept a new level only after DEB_CYCLES consecutive disagreeing samples
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            deb_lvl  <= '0;
            deb_prev <= '0;
            deb_cnt  <= '0;
        end else begin
            deb_prev <= deb_lvl;
            for (int i = 0; i < 2; i++) begin
                if (sync_2[i] != deb_lvl[i]) begin
                    if (deb_cnt[i] == DEB_MAX) begin
                        deb_lvl[i] <= sync_2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DW'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // state register plus registered clear request
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
            CLR   <= 1'b0;
        end else begin
            state <= state_nxt;
            CLR   <= clr_hon;
        end
    end

    // next state: clear wins over start/stop outside RUN, clear is ignored in RUN
    always_comb begin
        state_nxt = state;
        clr_hon   = 1'b0;
        case (state)
            S_IDLE: begin
                if (clr_press) begin
                    clr_hon = 1'b1;
                end else if (ss_press) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (ss_press) begin
                    state_nxt = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (clr_press) begin
                    state_nxt = S_IDLE;
                    clr_hon   = 1'b1;
                end else if (ss_press) begin
                    state_nxt = S_RUN;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // prescaler: counts in RUN, holds phase in PAUSE, zero whenever heading into IDLE
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            presc <= '0;
        end else if (state_nxt == S_IDLE) begin
            presc <= '0;
        end else if (state == S_RUN) begin
            presc <= (presc == PRE_MAX) ? '0 : presc + PW'(1);
        end
    end

    // outputs decoded from the current state
    always_comb begin
        STATE   = state;
        RUNNING = (state == S_RUN);
        TICK    = (state == S_RUN) && (presc == PRE_MAX);
    end

endmodule

// File: tb/tb_chrono_ctrl.sv
// tb/tb_chrono_ctrl.sv - scoreboard bench for chrono_ctrl with a behavioural event model
module tb_chrono_ctrl;

    localparam int DIV  = 10;
    localparam int DEB  = 4;
    localparam int MASK = (1 << DEB) - 1;

    localparam int EV_STATE = 0;
    localparam int EV_TICK  = 1;
    localparam int EV_CLR   = 2;

    logic       CLK;
    logic       RST;
    logic       BTN_SS;
    logic       BTN_CLR;
    logic       TICK;
    logic       CLR;
    logic [1:0] STATE;
    logic       RUNNING;

    chrono_ctrl #(
        .DIV        (DIV),
        .DEB_CYCLES (DEB)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .BTN_SS  (BTN_SS),
        .BTN_CLR (BTN_CLR),
        .TICK    (TICK),
        .CLR     (CLR),
        .STATE   (STATE),
        .RUNNING (RUNNING)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int cyc;
        int kind;
        int val;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;

    // behavioural model: raw samples delayed two edges, window-based debounce,
    // transition table, and RUN-cycle count modulo DIV for ticks
    int  m_state;
    int  m_run;
    int  m_deb[2];
    int  m_press[2];
    int  m_rh[2];
    int  m_xs[2];

    task automatic model_reset();
        m_state = 0;
        m_run   = 0;
        for (int b = 0; b < 2; b++) begin
            m_deb[b]   = 0;
            m_press[b] = 0;
            m_rh[b]    = 0;
            m_xs[b]    = 0;
        end
    endtask

    task automatic push_ev(input int kind, input int val);
        ev_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic step();
        int raw[2];
        int nxt;
        int clr_ev;
        int tick_ev;
        int x;
        int old;
        @(posedge CLK);
        raw[0] = int'(BTN_SS);
        raw[1] = int'(BTN_CLR);
        cyc++;
        nxt    = m_state;
        clr_ev = 0;
        case (m_state)
            0: if (m_press[1] != 0) clr_ev = 1;
               else if (m_press[0] != 0) nxt = 1;
            1: if (m_press[0] != 0) nxt = 2;
            2: if (m_press[1] != 0) begin nxt = 0; clr_ev = 1; end
               else if (m_press[0] != 0) nxt = 1;
            default: nxt = 0;
        endcase
        if (nxt == 0) m_run = 0;
        else if (nxt == 1) m_run++;
        tick_ev = (nxt == 1 && (m_run % DIV) == 0) ? 1 : 0;
        for (int b = 0; b < 2; b++) begin
            x        = (m_rh[b] >> 1) & 1;
            m_rh[b]  = ((m_rh[b] << 1) | raw[b]) & 3;
            m_xs[b]  = ((m_xs[b] << 1) | x) & MASK;
            old      = m_deb[b];
            if ((old != 0) ? (m_xs[b] == 0) : (m_xs[b] == MASK))
                m_deb[b] = 1 - old;
            m_press[b] = (m_deb[b] == 1 && old == 0) ? 1 : 0;
        end
        if (nxt != m_state) push_ev(EV_STATE, nxt);
        if (tick_ev != 0)   push_ev(EV_TICK, 1);
        if (clr_ev != 0)    push_ev(EV_CLR, 1);
        m_state = nxt;
        #1;
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic mon_check(input int kind, input int val);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_unexpected at cycle %0d: actual kind=%0d val=%0d, required none", cyc, kind, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val || e.cyc != cyc) begin
                failures++;
                $display("FAIL scoreboard_event: actual kind=%0d val=%0d cycle=%0d, required kind=%0d val=%0d cycle=%0d",
                         kind, val, cyc, e.kind, e.val, e.cyc);
            end
        end
    endtask

    task automatic drain_check();
        ev_t e;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL scoreboard_missing: actual none, required kind=%0d val=%0d cycle=%0d", e.kind, e.val, e.cyc);
        end
    endtask

    // monitor: every output event the DUT shows is popped against the model queue
    logic [1:0] mon_prev = 2'b00;
    always @(negedge CLK) begin
        if (!RST) begin
            mon_prev = 2'b00;
        end else begin
            if (STATE != mon_prev) begin
                mon_check(EV_STATE, int'(STATE));
                mon_prev = STATE;
            end
            if (TICK) mon_check(EV_TICK, 1);
            if (CLR)  mon_check(EV_CLR, 1);
            checks++;
            if (RUNNING != (STATE == 2'b01)) begin
                failures++;
                $display("FAIL running_decode at cycle %0d: actual=%0d required=%0d", cyc, RUNNING, (STATE == 2'b01));
            end
        end
    end

    task automatic reset_pulse();
        @(negedge CLK);
        #1;
        RST = 1'b0;
        #1;
        chk("rst_state", int'(STATE), 0);
        chk("rst_tick", int'(TICK), 0);
        chk("rst_clr", int'(CLR), 0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        drain_check();
        model_reset();
    endtask

    task automatic wait_state(input int s, input int budget);
        int n;
        n = 0;
        while (int'(STATE) != s && n < budget) begin
            step();
            n++;
        end
        chk("wait_state", int'(STATE), s);
    endtask

    task automatic press_btn(input int ss, input int clr, output int clr_cnt);
        clr_cnt = 0;
        BTN_SS  = ss[0];
        BTN_CLR = clr[0];
        repeat (10) begin step(); clr_cnt += int'(CLR); end
        BTN_SS  = 1'b0;
        BTN_CLR = 1'b0;
        repeat (10) begin step(); clr_cnt += int'(CLR); end
    endtask

    initial begin
        int n;
        int cnt;
        int tick_cnt;
        int r;
        BTN_SS  = 1'b0;
        BTN_CLR = 1'b0;
        RST     = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        chk("init_state", int'(STATE), 0);
        chk("init_tick", int'(TICK), 0);
        chk("init_clr", int'(CLR), 0);
        chk("init_running", int'(RUNNING), 0);
        @(posedge CLK);
        #1;
        RST = 1'b1;

        // bouncing start/stop: toggles every 2 cycles never debounce
        for (int i = 0; i < 15; i++) begin
            BTN_SS = ~BTN_SS;
            step();
            step();
        end
        BTN_SS = 1'b0;
        repeat (12) step();
        chk("bounce_state", int'(STATE), 0);

        // clean press held 20 cycles: RUN on the 6th edge after first capture
        BTN_SS = 1'b1;
        step();
        repeat (5) step();
        chk("ss_before_run", int'(STATE), 0);
        step();
        chk("ss_run", int'(STATE), 1);
        repeat (13) step();
        BTN_SS = 1'b0;
        repeat (30) step();

        // pause with the prescaler at 6, sit 50 cycles, resume
        n = 0;
        while ((m_run % DIV) != 0 && n < 2 * DIV) begin step(); n++; end
        BTN_SS = 1'b1;
        repeat (8) step();
        BTN_SS = 1'b0;
        chk("pause_state", int'(STATE), 2);
        repeat (50) step();
        BTN_SS = 1'b1;
        wait_state(1, 20);
        n = 1;
        while (!TICK && n < 20) begin step(); n++; end
        chk("resume_first_tick", n, 4);
        BTN_SS = 1'b0;
        repeat (12) step();

        // clear ignored in RUN, honored in PAUSE
        press_btn(0, 1, cnt);
        chk("clr_in_run_pulses", cnt, 0);
        chk("clr_in_run_state", int'(STATE), 1);
        press_btn(1, 0, cnt);
        chk("pause_again", int'(STATE), 2);
        press_btn(0, 1, cnt);
        chk("clr_in_pause_pulses", cnt, 1);
        chk("clr_in_pause_state", int'(STATE), 0);

        // simultaneous presses: PAUSE -> clear wins, RUN -> start/stop wins
        press_btn(1, 0, cnt);
        press_btn(1, 0, cnt);
        chk("to_pause", int'(STATE), 2);
        press_btn(1, 1, cnt);
        chk("both_pause_pulses", cnt, 1);
        chk("both_pause_state", int'(STATE), 0);
        press_btn(1, 0, cnt);
        chk("to_run", int'(STATE), 1);
        press_btn(1, 1, cnt);
        chk("both_run_pulses", cnt, 0);
        chk("both_run_state", int'(STATE), 2);

        // reset mid-RUN with prescaler at 5, then no ticks without a new press
        press_btn(1, 0, cnt);
        n = 0;
        while ((m_run % DIV) != 6 && n < 2 * DIV) begin step(); n++; end
        reset_pulse();
        tick_cnt = 0;
        repeat (40) begin step(); tick_cnt += int'(TICK); end
        chk("post_reset_ticks", tick_cnt, 0);
        chk("post_reset_state", int'(STATE), 0);

        // button held across reset counts as a fresh press
        BTN_SS = 1'b1;
        repeat (3) step();
        reset_pulse();
        wait_state(1, 20);
        BTN_SS = 1'b0;
        repeat (15) step();

        // randomized soak against the model
        for (int s = 0; s < 150; s++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                reset_pulse();
            end else begin
                BTN_SS  = ($urandom_range(0, 2) == 0);
                BTN_CLR = ($urandom_range(0, 3) == 0);
                repeat ($urandom_range(1, 12)) step();
            end
        end
        BTN_SS  = 1'b0;
        BTN_CLR = 1'b0;
        repeat (20) step();
        @(negedge CLK);
        #1;
        drain_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
